// File: rtl/fa_share_arbiter.sv
// fa_share_arbiter: round-robin share of one final carry-propagate adder
// between NUM_REQ carry-save lanes; two registered stages (S1 capture, S2 add).
// Optional build macro FA_SHARE_ROUND_EN: round half up with saturation
// instead of plain truncation with wrap.
module fa_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IN_W    = 20,
    parameter int unsigned OUT_W   = 14,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*IN_W-1:0] req_sum,
    input  logic [NUM_REQ*IN_W-1:0] req_carry,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [ID_W-1:0]         out_id
);

    localparam int unsigned IDX_W = ID_W + 1;
    localparam int unsigned SHIFT = IN_W - OUT_W;

    logic [ID_W-1:0]    rr_ptr,   rr_ptr_d;
    logic               s1_valid, s1_valid_d;
    logic [IN_W-1:0]    s1_sum,   s1_sum_d;
    logic [IN_W-1:0]    s1_carry, s1_carry_d;
    logic [ID_W-1:0]    s1_id,    s1_id_d;
    logic               out_valid_d;
    logic [OUT_W-1:0]   out_data_d;
    logic [ID_W-1:0]    out_id_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic               found;
    logic [IDX_W-1:0]   idx;
    logic [IN_W-1:0]    sel_sum;
    logic [IN_W-1:0]    sel_carry;
    logic               s2_free;
    logic               s1_free;
    logic               s1_move;
    logic               xfer;
    logic [OUT_W-1:0]   result;
`ifdef FA_SHARE_ROUND_EN
    localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
    logic [IN_W:0]      wide;
`else
    logic [IN_W-1:0]    sum_w;
`endif

    // Round-robin search: first requesting lane at or above rr_ptr, wrapping to 0
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'(rr_ptr) + IDX_W'(k);
            if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found                 = 1'b1;
                grant[idx[ID_W-1:0]] = 1'b1;
                gnt_id                = idx[ID_W-1:0];
            end
        end
    end

    // Operand mux for the granted lane; only ever steered by the grant
    always_comb begin
        sel_sum   = '0;
        sel_carry = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_sum   = req_sum[i*IN_W +: IN_W];
                sel_carry = req_carry[i*IN_W +: IN_W];
            end
        end
    end

    assign s2_free   = !out_valid | out_ready;
    assign s1_move   = s1_valid & s2_free;
    assign s1_free   = !s1_valid | s1_move;
    assign req_ready = grant & {NUM_REQ{s1_free & reset_n}};
    assign xfer      = |(req_valid & req_ready);

    // Final adder: truncate the top OUT_W bits, or round half up and saturate
    always_comb begin
`ifdef FA_SHARE_ROUND_EN
        wide   = {1'b0, s1_sum} + {1'b0, s1_carry} + RND;
        result = wide[IN_W] ? '1 : OUT_W'(wide >> SHIFT);
`else
        sum_w  = s1_sum + s1_carry;
        result = OUT_W'(sum_w >> SHIFT);
`endif
    end

    // Next-state: pointer advance, S1 capture/drain, S2 load/drain
    always_comb begin
        rr_ptr_d    = rr_ptr;
        s1_valid_d  = s1_valid;
        s1_sum_d    = s1_sum;
        s1_carry_d  = s1_carry;
        s1_id_d     = s1_id;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_id_d    = out_id;

        if (xfer) begin
            rr_ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            s1_valid_d = 1'b1;
            s1_sum_d   = sel_sum;
            s1_carry_d = sel_carry;
            s1_id_d    = gnt_id;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        if (s1_move) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_id_d    = s1_id;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards anything in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_carry  <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            rr_ptr    <= rr_ptr_d;
            s1_valid  <= s1_valid_d;
            s1_sum    <= s1_sum_d;
            s1_carry  <= s1_carry_d;
            s1_id     <= s1_id_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_id    <= out_id_d;
        end
    end

endmodule

// File: tb/tb_fa_share_arbiter.sv
// Directed bench for fa_share_arbiter (default parameters; honours FA_SHARE_ROUND_EN).
module tb_fa_share_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IN_W    = 20;
    localparam int unsigned OUT_W   = 14;
    localparam int unsigned ID_W    = 2;

    logic                    clk;
    logic                    reset_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*IN_W-1:0] req_sum;
    logic [NUM_REQ*IN_W-1:0] req_carry;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
    logic [ID_W-1:0]         out_id;

    int n_checks = 0;
    int n_errors = 0;

    fa_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sum   (req_sum),
        .req_carry (req_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Lane i carries (i+1) in the kept field, so out_data identifies the lane
    task automatic load_lane_pattern();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_sum[i*IN_W +: IN_W]   = IN_W'((i + 1) << 6);
            req_carry[i*IN_W +: IN_W] = '0;
        end
    endtask

    // One request on one lane with no stall: accept now, result two edges later
    task automatic send_one(input string tag, input int lane, input logic [19:0] s,
                            input logic [19:0] c, input logic [13:0] exp_d);
        @(negedge clk);
        req_valid = '0;
        req_valid[lane] = 1'b1;
        req_sum[lane*IN_W +: IN_W]   = s;
        req_carry[lane*IN_W +: IN_W] = c;
        out_ready = 1'b1;
        #1 check({tag, "_ready"}, 32'(req_ready), 32'(1 << lane));
        @(negedge clk);
        req_valid = '0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(exp_d));
        check({tag, "_id"},    32'(out_id),    32'(lane));
        @(negedge clk);
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    int order [8] = '{3, 0, 1, 2, 3, 0, 1, 2};

    initial begin
        reset_n   = 1'b0;
        req_valid = '1;
        req_sum   = '0;
        req_carry = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_id",    32'(out_id),    32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = '0;
        reset_n   = 1'b1;

        // Basic path: lane 2, 0x40 + 0x40 = 0x80 -> top 14 bits = 2
        send_one("lane2", 2, 20'h00040, 20'h00040, 14'h0002);

        // Continuous requests on all lanes, pointer now at 3
        load_lane_pattern();
        out_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            req_valid = (k <= 7) ? 4'hF : 4'h0;
            #1;
            if (k <= 7) check("rr_ready", 32'(req_ready), 32'(1 << order[k]));
            else        check("rr_ready_idle", 32'(req_ready), 32'd0);
            if (k >= 2 && k <= 9) begin
                check("rr_valid", 32'(out_valid), 32'd1);
                check("rr_id",    32'(out_id),    32'(order[k-2]));
                check("rr_data",  32'(out_data),  32'(order[k-2] + 1));
            end else begin
                check("rr_novalid", 32'(out_valid), 32'd0);
            end
        end

        // Backpressure: pointer at 3, so lanes 3 then 0 get in, then everything stalls
        @(negedge clk);
        req_valid = 4'hF;
        out_ready = 1'b0;
        #1 check("bp_ready0", 32'(req_ready), 32'h8);
        @(negedge clk);
        check("bp_ready1", 32'(req_ready), 32'h1);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_id",    32'(out_id),    32'd3);
            check("bp_data",  32'(out_data),  32'd4);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_valid", 32'(out_valid), 32'd1);
        check("bp_drain_id",    32'(out_id),    32'd0);
        check("bp_drain_data",  32'(out_data),  32'd1);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Arithmetic corners
`ifdef FA_SHARE_ROUND_EN
        send_one("wrap",  1, 20'hFFFFF, 20'h00001, 14'h3FFF);
        send_one("sat",   0, 20'hFFFFF, 20'h0001F, 14'h3FFF);
        send_one("half",  3, 20'h00020, 20'h00000, 14'h0001);
        send_one("mid",   2, 20'hABCDE, 20'h11111, 14'h2F38);
`else
        send_one("wrap",  1, 20'hFFFFF, 20'h00001, 14'h0000);
        send_one("sat",   0, 20'hFFFFF, 20'h0001F, 14'h0000);
        send_one("half",  3, 20'h00020, 20'h00000, 14'h0000);
        send_one("mid",   2, 20'hABCDE, 20'h11111, 14'h2F37);
`endif

        // Reset with both stages full; pointer is non-zero beforehand
        load_lane_pattern();
        @(negedge clk);
        req_valid = 4'hF;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_full", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1 check("post_rst_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        check("post_rst_lat", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_id",    32'(out_id),    32'd0);
        check("post_rst_data",  32'(out_data),  32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fa_share_arbiter.md
Name: fa_share_arbiter

Overview:
- Shares one final carry-propagate adder between NUM_REQ Wallace-tree lanes.
- Each lane presents a carry-save pair: a sum row and a carry row, both IN_W bits wide.
- The block arbitrates round-robin, adds the two rows, and truncates to the top OUT_W bits.
- It returns the result with the requester ID on a valid/ready output.
- Sits between the per-PE compressor trees and the accumulator/activation stage.

Parameters:
- NUM_REQ, 4: number of requesting lanes (2..16).
- IN_W, 20: carry-save row width.
- OUT_W, 14: result width, taken as bits [IN_W-1 -: OUT_W] of the sum.
- ID_W, 2: requester-ID width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-lane request.
- req_ready  out  NUM_REQ  per-lane accept; one-hot or zero.
- req_sum  in  NUM_REQ*IN_W  lane i sum row at [i*IN_W +: IN_W].
- req_carry  in  NUM_REQ*IN_W  lane i carry row, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_W  truncated sum.
- out_id  out  ID_W  index of the lane that produced out_data.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- Reset values: all pipeline valids 0, out_valid 0, out_data 0, out_id 0, rr_ptr 0. req_ready is 0 while reset_n is low.
- Arbitration is combinational round-robin:
  - The grant goes to the first asserted req_valid at or after rr_ptr, searching upward with wrap to 0.
  - req_ready[g] = grant[g] & s1_free. All other req_ready bits are 0.
  - req_ready never depends on req_sum or req_carry.
- Handshake: a transfer occurs when req_valid[g] and req_ready[g] are both high.
  - On a transfer, rr_ptr <= (g+1) mod NUM_REQ.
  - If no transfer occurs, rr_ptr holds.
- Lane rule: a lane must hold req_valid and its data stable until accepted. The arbiter must never drop an accepted request.
- Pipeline is two registered stages, S1 and S2:
  - S1 captures sum, carry and id on a transfer.
  - S2 computes (sum + carry) mod 2^IN_W, then takes the top OUT_W bits. Lower bits are discarded, not rounded (default build).
  - S2 drives out_valid, out_data and out_id directly from flops.
- Latency: 2 cycles from the accepting edge to out_valid, when no stall.
- Throughput: 1 result per cycle when out_ready is held high.
- Flow control:
  - s2_free = !out_valid | out_ready.
  - S1 moves to S2 when S1 is valid and s2_free.
  - s1_free = !s1_valid | (s1_valid & s2_free).
  - Bubbles collapse.
- Backpressure: while out_ready is low and out_valid is high, out_data and out_id hold stable. S1 holds, and once S1 is full, all req_ready bits are 0.
- Simultaneous events: an S2 drain, an S1→S2 move and a new S1 capture may all happen on the same edge.
- Overflow: a carry out of bit IN_W-1 is dropped (wrap). This matches the existing tree arithmetic.
- Reset asserted mid-operation: in-flight results are discarded, all valids clear immediately, and rr_ptr returns to 0.

Optional Feature:
- Macro: FA_SHARE_ROUND_EN.
- Defined:
  - S2 computes sum + carry + (1 << (IN_W-OUT_W-1)) in IN_W+1 bits.
  - If bit IN_W is set, out_data saturates to all ones. Otherwise the top OUT_W bits of the IN_W-bit field are used.
  - Latency is unchanged.
- Undefined: plain truncation with wrap, as described in Behaviour.

Test Plan:
- Lane 2 only, sum=0x00040, carry=0x00040, out_ready=1 -> 2 cycles later out_valid=1, out_data=0x0002, out_id=2.
- All four lanes valid continuously, out_ready=1 -> grants in order 0,1,2,3,0,...; one result per cycle; out_id sequence matches.
- out_ready held 0 for 5 cycles with lanes requesting -> out_data/out_id stable; exactly 2 requests accepted, then req_ready=0; releasing out_ready drains in order with no loss or duplication.
- sum=0xFFFFF, carry=0x00001 -> out_data=0x0000 (wrap). With FA_SHARE_ROUND_EN, sum=0xFFFFF, carry=0x0001F -> out_data=0x3FFF (saturate).
- With FA_SHARE_ROUND_EN, sum=0x00020, carry=0x00000 -> out_data=0x0001 (round half up). Without the macro -> 0x0000.
- Assert reset_n low with both stages full -> out_valid drops asynchronously. After release, the first grant goes to lane 0 when all lanes request.
